icache: RTL and testbench

Direct-mapped instruction cache answering the fetch stage's instruction requests. It returns the stored instruction combinationally, in the same cycle, on a hit. On a miss it refills one 32-bit word by issuing four byte reads through the memory-controller arbiter. It sits between the fetch stage and the memory arbiter, and drives the fetch stage's instruction-valid input that releases the fetch stall.

---
 rtl/icache_pkg.sv | 30 +++
 rtl/icache_line_array.sv | 56 +++++
 rtl/icache.sv | 150 +++++++++++++++
 tb/tb_icache.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   state_t         refill controller states
//   ADDR_W/INSTR_W  default address width and instruction word width
//   BYTES_PER_WORD  bytes fetched from the arbiter per refill
//   addr_index/tag  address split helpers (word-aligned, byte offset dropped)
package icache_pkg;

  localparam int ADDR_W         = 32;
  localparam int INSTR_W        = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FILL
  } state_t;

  // Line index: the bits just above the byte offset.
  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                   input int               index_bits);
    return (addr >> 2) & ((ADDR_W'(1) << index_bits) - ADDR_W'(1));
  endfunction

  // Tag: everything above the index.
  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                 input int               index_bits);
    return addr >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache, one 32-bit word per line.
//   clk                         clock
//   clear                       synchronous invalidate of every line
//   rd_index                    combinational read port address
//   rd_valid/rd_tag/rd_data     line contents at rd_index
//   wr_en/wr_index/wr_tag/wr_data  synchronous line write, sets valid
module icache_line_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 7,
  parameter int TAG_W      = 23
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [INSTR_W-1:0]    rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [INSTR_W-1:0]    wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [INSTR_W-1:0] data_q [LINES];

  // Clear wins over a simultaneous write so an aborted refill never leaves
  // a valid line behind.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays have no reset; the valid bits alone make stale
  // contents unreachable, and leaving them unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetch stage and the memory
// arbiter. Hits return combinationally; a miss refills one word with four
// byte reads through the arbiter.
//   clk, rst                synchronous active-high reset
//   if_req_i, if_addr_i     fetch request and address (bits [1:0] ignored)
//   if_valid_o, if_inst_o   hit indication and instruction (zero on no hit)
//   mem_req_o, mem_addr_o   byte read request to the arbiter
//   mem_grant_i             arbiter accepts the request this cycle
//   mem_data_i              read byte, valid the cycle after a grant
module icache #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        if_req_i,
  input  logic [ADDR_W-1:0]           if_addr_i,
  output logic                        if_valid_o,
  output logic [icache_pkg::INSTR_W-1:0] if_inst_o,
  output logic                        mem_req_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  input  logic                        mem_grant_i,
  input  logic [7:0]                  mem_data_i
);

  import icache_pkg::*;

  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     miss_addr_q;
  logic [2:0]            send_cnt_q;
  logic [2:0]            recv_cnt_q;
  logic                  byte_pending_q;
  logic [INSTR_W-1:0]    fill_word_q;

  logic [INDEX_BITS-1:0] req_index, miss_index;
  logic [TAG_W-1:0]      req_tag, miss_tag;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [INSTR_W-1:0]    line_data;
  logic                  hit;
  logic                  wr_en;
  logic                  byte_granted;
  logic                  last_byte;

  assign req_index  = INDEX_BITS'(addr_index(if_addr_i, INDEX_BITS));
  assign req_tag    = TAG_W'(addr_tag(if_addr_i, INDEX_BITS));
  assign miss_index = INDEX_BITS'(addr_index(miss_addr_q, INDEX_BITS));
  assign miss_tag   = TAG_W'(addr_tag(miss_addr_q, INDEX_BITS));

  icache_line_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk     (clk),
    .clear   (rst),
    .rd_index(req_index),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .wr_en   (wr_en),
    .wr_index(miss_index),
    .wr_tag  (miss_tag),
    .wr_data (fill_word_q)
  );

  // Hits are only served from IDLE, so a line being refilled is never
  // forwarded early.
  assign hit = if_req_i && line_valid && (line_tag == req_tag) &&
               (state_q == IDLE) && !rst;

  assign byte_granted = mem_req_o && mem_grant_i;
  // The byte granted last cycle is arriving now; if it is lane 3 the word
  // is complete.
  assign last_byte    = byte_pending_q && (recv_cnt_q == 3'(BYTES_PER_WORD - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no path
  // through the case statement infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (if_req_i && !hit) state_d = FETCH;
      FETCH:   if (last_byte)        state_d = FILL;
      FILL:                          state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    wr_en      = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_req_o = !rst && (send_cnt_q < 3'(BYTES_PER_WORD));
        // miss_addr is word-aligned and send_cnt < 4, so the sum never
        // carries out of the byte offset.
        if (mem_req_o) mem_addr_o = miss_addr_q + ADDR_W'(send_cnt_q);
      end
      FILL:    wr_en = !rst;
      default: ;
    endcase
    if_valid_o = hit;
    if_inst_o  = hit ? line_data : '0;
  end

  // Refill datapath: miss address, byte counters and word assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_addr_q    <= '0;
      send_cnt_q     <= '0;
      recv_cnt_q     <= '0;
      byte_pending_q <= 1'b0;
      fill_word_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (if_req_i && !hit) begin
            miss_addr_q    <= {if_addr_i[ADDR_W-1:2], 2'b00};
            send_cnt_q     <= '0;
            recv_cnt_q     <= '0;
            byte_pending_q <= 1'b0;
          end
        end
        FETCH: begin
          if (byte_granted) send_cnt_q <= send_cnt_q + 3'd1;
          byte_pending_q <= byte_granted;
          if (byte_pending_q) begin
            fill_word_q[8*recv_cnt_q[1:0] +: 8] <= mem_data_i;
            recv_cnt_q                          <= recv_cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  localparam int INDEX_BITS = 7;
  localparam int ADDR_W     = 32;
  localparam int LINES      = 1 << INDEX_BITS;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_valid_o;
  logic [31:0]       if_inst_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_grant_i;
  logic [7:0]        mem_data_i;

  icache #(.INDEX_BITS(INDEX_BITS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_valid_o (if_valid_o),
    .if_inst_o  (if_inst_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_grant_i(mem_grant_i),
    .mem_data_i (mem_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    int          issue;
    int          lat;
  } txn_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  txn_t        txn_q[$];
  logic [31:0] exp_addr_q[$];
  bit          grant_q[$];

  // Reference cache contents: which line address each index holds.
  bit          model_valid[LINES];
  logic [31:0] model_line [LINES];

  // Backing memory: two fixed words from the test plan, hashed contents elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'd3;
    if (w == 32'h0)   return 32'h0000_0013;
    if (w == 32'h200) return 32'h0010_0093;
    return (w * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return 8'(w >> (8 * (a % 4)));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every hit the DUT presents must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_valid_o) begin
        if (txn_q.size() == 0) begin
          check("unexpected_valid", {31'd0, if_valid_o}, 32'd0);
        end else begin
          txn_t t;
          t = txn_q.pop_front();
          check("inst", if_inst_o, t.inst);
          check("hit_latency", cyc - t.issue, t.lat);
        end
      end else if (if_inst_o !== 32'd0) begin
        check("inst_zero_when_invalid", if_inst_o, 32'd0);
      end
    end
  end

  // Arbiter/memory responder: checks each granted address, returns the byte next cycle.
  logic        pend  = 1'b0;
  logic [31:0] paddr = '0;

  always @(negedge clk) begin
    pend = mem_req_o && mem_grant_i;
    if (pend) begin
      paddr = mem_addr_o;
      if (exp_addr_q.size() == 0) check("unexpected_mem_req", {31'd0, mem_req_o}, 32'd0);
      else check("mem_addr", mem_addr_o, exp_addr_q.pop_front());
    end
  end

  always @(posedge clk) begin
    #1;
    mem_data_i = pend ? mem_byte(paddr) : 8'($urandom);
  end

  task automatic summary_and_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    mem_grant_i = (grant_q.size() != 0) ? grant_q.pop_front() : 1'($urandom);
  endtask

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
    txn_q.delete();
    exp_addr_q.delete();
    grant_q.delete();
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (txn_q.size() == 0) break;
      n++;
      if (n > bound) begin
        checks++;
        failures++;
        $display("FAIL timeout waiting for if_valid_o at cycle %0d", cyc);
        summary_and_finish();
      end
      step();
    end
    grant_q.delete();
  endtask

  // Issue one request and predict hit/miss and latency from the model.
  // On a miss, stall_len grant-low cycles precede the grant of byte stall_pos.
  task automatic do_req(input logic [31:0] addr, input int stall_pos, input int stall_len);
    int          idx;
    logic [31:0] line;
    txn_t        t;
    idx  = int'((addr >> 2) % LINES);
    line = addr & ~32'd3;
    step();
    if_req_i  = 1'b1;
    if_addr_i = addr;
    t.inst    = mem_word(addr);
    t.issue   = cyc;
    if (model_valid[idx] && model_line[idx] == line) begin
      t.lat = 0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (b == stall_pos) repeat (stall_len) grant_q.push_back(1'b0);
        grant_q.push_back(1'b1);
        exp_addr_q.push_back(line + b);
      end
      t.lat            = 7 + stall_len;
      model_valid[idx] = 1'b1;
      model_line[idx]  = line;
    end
    txn_q.push_back(t);
    wait_done(60);
  endtask

  task automatic do_reset();
    step();
    rst       = 1'b1;
    if_req_i  = 1'b1;
    if_addr_i = 32'h0;
    step();
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_if_valid", {31'd0, if_valid_o}, 32'd0);
    check("rst_if_inst", if_inst_o, 32'd0);
    step();
    rst      = 1'b0;
    if_req_i = 1'b0;
    clear_model();
  endtask

  // Address changes from 0x4 to 0x40 during the 0x4 refill.
  task automatic do_change();
    txn_t t;
    step();
    if_req_i  = 1'b1;
    if_addr_i = 32'h4;
    t.inst    = mem_word(32'h40);
    t.issue   = cyc;
    t.lat     = 14;
    repeat (11) grant_q.push_back(1'b1);
    for (int b = 0; b < 4; b++) exp_addr_q.push_back(32'h4 + b);
    for (int b = 0; b < 4; b++) exp_addr_q.push_back(32'h40 + b);
    txn_q.push_back(t);
    model_valid[1]  = 1'b1; model_line[1]  = 32'h4;
    model_valid[16] = 1'b1; model_line[16] = 32'h40;
    step();
    step();
    if_addr_i = 32'h40;
    wait_done(60);
  endtask

  // Reset while a refill of 0x10 is in FETCH.
  task automatic do_reset_mid_fetch();
    step();
    if_req_i  = 1'b1;
    if_addr_i = 32'h10;
    repeat (4) grant_q.push_back(1'b1);
    for (int b = 0; b < 4; b++) exp_addr_q.push_back(32'h10 + b);
    step();
    step();
    rst      = 1'b1;
    if_req_i = 1'b0;
    step();
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    check("mem_req_after_rst", {31'd0, mem_req_o}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    mem_grant_i = 1'b0;
    mem_data_i  = '0;
    clear_model();
    do_reset();

    // Directed scenarios
    do_req(32'h0, 0, 0);     // miss, hit at cycle 7
    do_req(32'h0, 0, 0);     // same-cycle hit
    do_req(32'h200, 0, 0);   // conflicting tag, miss
    do_req(32'h200, 0, 0);   // hit
    do_req(32'h0, 0, 0);     // evicted, miss again
    do_req(32'h8, 1, 3);     // grant low 3 cycles on byte +1, hit at cycle 10
    do_reset();
    do_change();
    do_req(32'h4, 0, 0);     // 0x4 line completed and valid
    do_req(32'h0, 0, 0);
    do_reset_mid_fetch();
    do_req(32'h0, 0, 0);     // invalidated by reset, miss
    do_req(32'h1FC, 2, 2);   // last index
    do_req(32'h1FF, 0, 0);   // same word, low bits ignored: hit

    // Randomized traffic over a few indices and tags to force conflicts.
    for (int n = 0; n < 200; n++) begin
      int          idx;
      logic [31:0] addr;
      case ($urandom_range(3))
        0:       idx = 0;
        1:       idx = LINES - 1;
        2:       idx = 1;
        default: idx = int'($urandom_range(LINES - 1));
      endcase
      addr = (32'($urandom_range(2)) << (INDEX_BITS + 2)) | (32'(idx) << 2) |
             32'($urandom_range(3));
      do_req(addr, int'($urandom_range(3)), int'($urandom_range(3)));
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          step();
          if_req_i  = 1'b0;
          if_addr_i = $urandom;
        end
      end
    end

    step();
    if_req_i = 1'b0;
    repeat (3) step();
    summary_and_finish();
  end

endmodule
